// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames raw PS/2 serial data, decodes make/break scancodes into 4-bit key codes.
// Optional parity checking is enabled with `define PS2_PARITY_CHECK_EN.
module ps2_key_decoder #(
  parameter int CLK_FREQ_HZ = 65_000_000,
  parameter int TIMEOUT_US  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);

  localparam logic [3:0] KEY_RELESED = 4'd0;
  localparam logic [3:0] KEY_A       = 4'd1;
  localparam logic [3:0] KEY_S       = 4'd2;
  localparam logic [3:0] KEY_W       = 4'd3;
  localparam logic [3:0] KEY_D       = 4'd4;
  localparam logic [3:0] KEY_1       = 4'd5;
  localparam logic [3:0] KEY_2       = 4'd6;
  localparam logic [3:0] KEY_3       = 4'd7;
  localparam logic [3:0] KEY_4       = 4'd8;
  localparam logic [3:0] KEY_ESC     = 4'd9;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } state_t;

  // Returns {mapped, key}; mapped=0 for scancodes the game does not use.
  function automatic logic [4:0] map_scan(input logic [7:0] sc);
    case (sc)
      8'h1C:   map_scan = {1'b1, KEY_A};
      8'h1B:   map_scan = {1'b1, KEY_S};
      8'h1D:   map_scan = {1'b1, KEY_W};
      8'h23:   map_scan = {1'b1, KEY_D};
      8'h16:   map_scan = {1'b1, KEY_1};
      8'h1E:   map_scan = {1'b1, KEY_2};
      8'h26:   map_scan = {1'b1, KEY_3};
      8'h25:   map_scan = {1'b1, KEY_4};
      8'h76:   map_scan = {1'b1, KEY_ESC};
      default: map_scan = 5'b0_0000;
    endcase
  endfunction

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          fall;
  logic          din;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic [TW-1:0] wd_cnt;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          err_pulse;
`ifdef PS2_PARITY_CHECK_EN
  logic          parity_bit;
`endif

  state_t        state;
  state_t        state_n;
  logic [3:0]    key_reg;
  logic [3:0]    key_n;
  logic          valid_reg;
  logic [4:0]    map_res;

  // Bit 2 of clk_sync is the previous synchronised level, used for edge detection.
  assign fall = clk_sync[2] & ~clk_sync[1];
  assign din  = data_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Frame receiver with idle watchdog; byte_valid and err_pulse land one cycle after the stop edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      wd_cnt     <= '0;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      err_pulse  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      byte_valid <= 1'b0;
      err_pulse  <= 1'b0;
      if (fall) begin
        wd_cnt <= '0;
        case (bit_cnt)
          4'd0: begin
            if (din) begin
              err_pulse <= 1'b1;
            end else begin
              bit_cnt <= 4'd1;
            end
          end
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
            shift   <= {din, shift[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
          4'd9: begin
`ifdef PS2_PARITY_CHECK_EN
            parity_bit <= din;
`endif
            bit_cnt <= 4'd10;
          end
          4'd10: begin
            bit_cnt <= 4'd0;
            if (!din) begin
              err_pulse <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
            end else if ((^shift ^ parity_bit) != 1'b1) begin
              err_pulse <= 1'b1;
`endif
            end else begin
              byte_data  <= shift;
              byte_valid <= 1'b1;
            end
          end
          default: bit_cnt <= 4'd0;
        endcase
      end else if (bit_cnt != 4'd0) begin
        if (wd_cnt == TW'(TIMEOUT_CYC - 1)) begin
          bit_cnt <= 4'd0;
          wd_cnt  <= '0;
        end else begin
          wd_cnt <= wd_cnt + TW'(1);
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  // Scancode FSM state and registered key outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_reg   <= KEY_RELESED;
      valid_reg <= 1'b0;
    end else begin
      state     <= state_n;
      key_reg   <= key_n;
      valid_reg <= (key_n != key_reg);
    end
  end

  // Next-state and next-key decode for each received byte.
  always_comb begin
    state_n = state;
    key_n   = key_reg;
    map_res = map_scan(byte_data);
    if (byte_valid) begin
      case (state)
        IDLE: begin
          if (byte_data == SC_BREAK) begin
            state_n = BREAK;
          end else if (byte_data == SC_EXT) begin
            state_n = EXT;
          end else if (map_res[4]) begin
            key_n = map_res[3:0];
          end else begin
            state_n = IDLE;
          end
        end
        BREAK: begin
          state_n = IDLE;
          // Only releasing the currently held key clears it; older keys were superseded.
          if (map_res[4] && (map_res[3:0] == key_reg)) begin
            key_n = KEY_RELESED;
          end else begin
            key_n = key_reg;
          end
        end
        EXT: begin
          if (byte_data == SC_BREAK) begin
            state_n = EXT_BREAK;
          end else begin
            state_n = IDLE;
          end
        end
        EXT_BREAK: state_n = IDLE;
        default:   state_n = IDLE;
      endcase
    end else begin
      state_n = state;
    end
  end

  assign key_code  = key_reg;
  assign key_valid = valid_reg;
  assign frame_err = err_pulse;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed table-driven bench for ps2_key_decoder; honours PS2_PARITY_CHECK_EN for the parity vector.
module tb_ps2_key_decoder;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key_code;
  logic       key_valid;
  logic       frame_err;

  int checks;
  int failures;
  int kv_cnt;
  int fe_cnt;
  int both_cnt;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  ps2_key_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_code (key_code),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
    if (key_valid && frame_err) both_cnt++;
  end

  typedef struct {
    logic [7:0] sc;
    logic       bad_par;
    logic       bad_stop;
    logic       lone_start;
    logic [3:0] exp_key;
    int         exp_kv;
    int         exp_fe;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] sc, input logic bad_par,
                                             input logic bad_stop);
    logic p;
    p = ~(^sc);
    if (bad_par) p = ~p;
    return {~bad_stop, p, sc, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] sc);
    send_bits(make_frame(sc, 1'b0, 1'b0), 11);
    repeat (60) @(negedge clk);
  endtask

  // Sends 10 bits normally, then the stop edge with per-cycle sampling afterwards.
  task automatic send_timed(input logic [7:0] sc, input logic bad_stop,
                            output logic [5:0] kv_s, output logic [5:0] fe_s,
                            output logic [3:0] key3, output logic [3:0] key4);
    logic [10:0] f;
    f = make_frame(sc, 1'b0, bad_stop);
    send_bits(f, 10);
    @(negedge clk);
    ps2_data = f[10];
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    key3 = 4'd0;
    key4 = 4'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      kv_s[k] = key_valid;
      fe_s[k] = frame_err;
      if (k == 2) key3 = key_code;
      if (k == 3) key4 = key_code;
    end
    repeat (14) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  initial begin
    int kv0;
    int fe0;
    logic [5:0] kv_s;
    logic [5:0] fe_s;
    logic [3:0] k3;
    logic [3:0] k4;
    logic [3:0] par_key;

    checks   = 0;
    failures = 0;
    kv_cnt   = 0;
    fe_cnt   = 0;
    both_cnt = 0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rst      = 1'b1;

    par_key = PAR_EN ? 4'd0 : 4'd1;
    //          sc     bpar  bstop lone  key    kv  fe
    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 4'd1,  1,  0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 4'd1,  0,  0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 4'd0,  1,  0};
    vecs[3]  = '{8'h76, 1'b0, 1'b0, 1'b0, 4'd9,  1,  0};
    vecs[4]  = '{8'h76, 1'b0, 1'b0, 1'b0, 4'd9,  0,  0};
    vecs[5]  = '{8'h76, 1'b0, 1'b0, 1'b0, 4'd9,  0,  0};
    vecs[6]  = '{8'h1D, 1'b0, 1'b0, 1'b0, 4'd3,  1,  0};
    vecs[7]  = '{8'h23, 1'b0, 1'b0, 1'b0, 4'd4,  1,  0};
    vecs[8]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 4'd4,  0,  0};
    vecs[9]  = '{8'h1D, 1'b0, 1'b0, 1'b0, 4'd4,  0,  0};
    vecs[10] = '{8'hF0, 1'b0, 1'b0, 1'b0, 4'd4,  0,  0};
    vecs[11] = '{8'h23, 1'b0, 1'b0, 1'b0, 4'd0,  1,  0};
    vecs[12] = '{8'h1C, 1'b1, 1'b0, 1'b0, par_key, PAR_EN ? 0 : 1, PAR_EN ? 1 : 0};
    vecs[13] = '{8'h55, 1'b0, 1'b0, 1'b0, par_key, 0, 0};
    vecs[14] = '{8'h1B, 1'b0, 1'b1, 1'b0, par_key, 0, 1};
    vecs[15] = '{8'h00, 1'b0, 1'b0, 1'b1, par_key, 0, 1};
    vecs[16] = '{8'h1B, 1'b0, 1'b0, 1'b0, 4'd2,  1,  0};
    vecs[17] = '{8'hE0, 1'b0, 1'b0, 1'b0, 4'd2,  0,  0};
    vecs[18] = '{8'h1C, 1'b0, 1'b0, 1'b0, 4'd2,  0,  0};
    vecs[19] = '{8'hE0, 1'b0, 1'b0, 1'b0, 4'd2,  0,  0};
    vecs[20] = '{8'hF0, 1'b0, 1'b0, 1'b0, 4'd2,  0,  0};
    vecs[21] = '{8'h1B, 1'b0, 1'b0, 1'b0, 4'd2,  0,  0};
    vecs[22] = '{8'hF0, 1'b0, 1'b0, 1'b0, 4'd2,  0,  0};
    vecs[23] = '{8'h1B, 1'b0, 1'b0, 1'b0, 4'd0,  1,  0};

    repeat (3) @(negedge clk);
    check("reset_key_code", int'(key_code), 0);
    check("reset_key_valid", int'(key_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Decode a key, then reset in the middle of the following frame.
    send_frame(8'h1C);
    check("pre_reset_key", int'(key_code), 1);
    send_bits(make_frame(8'h76, 1'b0, 1'b0), 5);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_key_code", int'(key_code), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("postreset_key_code", int'(key_code), 0);
    check("postreset_key_valid", int'(key_valid), 0);

    foreach (vecs[i]) begin
      kv0 = kv_cnt;
      fe0 = fe_cnt;
      if (vecs[i].lone_start) begin
        send_bits(11'h7FF, 1);
        repeat (60) @(negedge clk);
      end else begin
        send_bits(make_frame(vecs[i].sc, vecs[i].bad_par, vecs[i].bad_stop), 11);
        repeat (60) @(negedge clk);
      end
      check($sformatf("vec%0d_key_code", i), int'(key_code), int'(vecs[i].exp_key));
      check($sformatf("vec%0d_key_valid_pulses", i), kv_cnt - kv0, vecs[i].exp_kv);
      check($sformatf("vec%0d_frame_err_pulses", i), fe_cnt - fe0, vecs[i].exp_fe);
    end

    // Extended make, then a partial frame abandoned by the idle watchdog.
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_frame(8'hE0);
    send_frame(8'h1C);
    send_bits(make_frame(8'h26, 1'b0, 1'b0), 6);
    repeat (16250) @(negedge clk);
    check("timeout_key_before", int'(key_code), 0);
    send_frame(8'h16);
    check("timeout_key_after", int'(key_code), 5);
    check("timeout_kv_pulses", kv_cnt - kv0, 1);
    check("timeout_fe_pulses", fe_cnt - fe0, 0);

    // Exact latency: byte/err at N+1 (sample 3), key change at N+2 (sample 4).
    send_timed(8'h1C, 1'b0, kv_s, fe_s, k3, k4);
    check("timed_kv_samples", int'(kv_s), 6'b001000);
    check("timed_fe_samples", int'(fe_s), 6'b000000);
    check("timed_key_at_n1", int'(k3), 5);
    check("timed_key_at_n2", int'(k4), 1);
    send_timed(8'h1E, 1'b1, kv_s, fe_s, k3, k4);
    check("stoperr_fe_samples", int'(fe_s), 6'b000100);
    check("stoperr_kv_samples", int'(kv_s), 6'b000000);
    check("stoperr_key", int'(key_code), 1);

    check("kv_fe_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
